// File: rtl/reaction_game_controller.sv
// Reaction-time game controller: start, random delay, go, measure, result.
// A single registered FSM drives the delay counter, the go indicator and the
// result flags, and counts milliseconds while the go indicator is lit.
module reaction_game_controller #(
    parameter logic [13:0] REACT_MAX = 14'd9999
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Press,
    input  logic        MsTick,
    input  logic        DelayDone,
    output logic        DelayEnable,
    output logic        GoLed,
    output logic [13:0] ReactionTime,
    output logic        ResultValid,
    output logic        FalseStart,
    output logic        Timeout,
    output logic [2:0]  State
);

    localparam int unsigned CNT_W = 14;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t             state;
    logic               start_prev;
    logic               press_prev;
    logic [CNT_W-1:0]   ms_count;

    logic               start_rise_c;
    logic               press_rise_c;
    logic               begin_round_c;

    // Button rising edges; previous-value registers reset high so held buttons do not fire
    assign start_rise_c  = Start & ~start_prev;
    assign press_rise_c  = Press & ~press_prev;

    // A new round may only start from an idle or finished state
    assign begin_round_c = start_rise_c &&
                           ((state == S_IDLE) || (state == S_RESULT) || (state == S_FAULT));

    assign State = state;

    // Game FSM with registered Moore outputs and the millisecond counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_IDLE;
            start_prev   <= 1'b1;
            press_prev   <= 1'b1;
            ms_count     <= '0;
            ReactionTime <= '0;
            DelayEnable  <= 1'b0;
            GoLed        <= 1'b0;
            ResultValid  <= 1'b0;
            FalseStart   <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            start_prev <= Start;
            press_prev <= Press;

            if (begin_round_c) begin
                state        <= S_DELAY;
                ms_count     <= '0;
                ReactionTime <= '0;
                DelayEnable  <= 1'b1;
                GoLed        <= 1'b0;
                ResultValid  <= 1'b0;
                FalseStart   <= 1'b0;
                Timeout      <= 1'b0;
            end else begin
                case (state)
                    S_DELAY: begin
                        // A press beats a simultaneous delay-done
                        if (press_rise_c) begin
                            state        <= S_FAULT;
                            DelayEnable  <= 1'b0;
                            FalseStart   <= 1'b1;
                            ReactionTime <= '0;
                        end else if (DelayDone) begin
                            state       <= S_GO;
                            DelayEnable <= 1'b0;
                            GoLed       <= 1'b1;
                        end
                    end
                    S_GO: begin
                        // A press beats a simultaneous tick; the tick is dropped
                        if (press_rise_c) begin
                            state        <= S_RESULT;
                            ReactionTime <= ms_count;
                            GoLed        <= 1'b0;
                            ResultValid  <= 1'b1;
                        end else if (MsTick) begin
                            if (ms_count == REACT_MAX) begin
                                state        <= S_RESULT;
                                ReactionTime <= REACT_MAX;
                                GoLed        <= 1'b0;
                                Timeout      <= 1'b1;
                            end else begin
                                ms_count <= ms_count + CNT_W'(1);
                            end
                        end
                    end
                    S_IDLE, S_RESULT, S_FAULT: begin
                        // Hold until a start edge; presses are ignored here
                    end
                    default: begin
                        state        <= S_IDLE;
                        ms_count     <= '0;
                        ReactionTime <= '0;
                        DelayEnable  <= 1'b0;
                        GoLed        <= 1'b0;
                        ResultValid  <= 1'b0;
                        FalseStart   <= 1'b0;
                        Timeout      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/reaction_game_controller.md
REACTION_GAME_CONTROLLER -- requirements
Module: reaction_game_controller

Interface
REQ-001 Parameter REACT_MAX, default 14'd9999, is the reaction-time saturation/timeout count in milliseconds.
REQ-002 Clock  input  1  the single system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high; sampled on the Clock rising edge.
REQ-004 Start  input  1  player start button, debounced and synchronous to Clock; acted on at its rising edge.
REQ-005 Press  input  1  player reaction button, debounced and synchronous; acted on at its rising edge.
REQ-006 MsTick  input  1  one-Clock-wide strobe, once per millisecond.
REQ-007 DelayDone  input  1  done flag from the random-delay counter.
REQ-008 DelayEnable  output  1  runs the delay counter while high; low holds it cleared.
REQ-009 GoLed  output  1  "react now" indicator.
REQ-010 ReactionTime  output  14  measured reaction time in ms.
REQ-011 ResultValid  output  1  ReactionTime is final.
REQ-012 FalseStart  output  1  Press occurred before GoLed.
REQ-013 Timeout  output  1  no Press within REACT_MAX ms.
REQ-014 State  output  3  current FSM state encoding, for debug display.

Function
REQ-015 Edge detect: one registered copy each of Start and Press; rise = current & ~previous; the previous-value registers reset to 1, so buttons held through reset do not trigger.
REQ-016 States/encoding: IDLE=0, DELAY=1, GO=2, RESULT=3, FAULT=4; codes 5-7 go to IDLE on the next clock.
REQ-017 All outputs are registered Moore outputs; a qualifying event sampled on edge n changes state and outputs at edge n.
REQ-018 IDLE: Start rise -> DELAY; ReactionTime, the ms counter and all flags are cleared on the same edge.
REQ-019 DELAY: DelayEnable=1; Press rise -> FAULT; otherwise DelayDone=1 -> GO; Press rise wins over a simultaneous DelayDone.
REQ-020 GO: GoLed=1, DelayEnable=0; the 14-bit ms counter increments on each MsTick and never exceeds REACT_MAX.
REQ-021 GO + Press rise -> RESULT; ReactionTime latches the pre-increment counter value; an MsTick in the same cycle is ignored.
REQ-022 GO + MsTick with counter==REACT_MAX and no Press rise -> RESULT with Timeout=1 and ReactionTime=REACT_MAX; a simultaneous Press rise takes priority and Timeout stays 0.
REQ-023 RESULT: ResultValid=1 and ReactionTime held; Start rise -> DELAY with clears as in REQ-018.
REQ-024 FAULT: FalseStart=1, ReactionTime=0; Start rise -> DELAY with clears as in REQ-018.
REQ-025 Start rise in DELAY or GO is ignored; Press rise in IDLE, RESULT or FAULT is ignored.
REQ-026 DelayEnable is low in every state except DELAY, so leaving DELAY always clears the delay counter.
REQ-027 GoLed, ResultValid, FalseStart and Timeout are mutually exclusive; at most one is high in any cycle.

Reset
REQ-028 Reset=1 at a Clock edge forces: State=IDLE; DelayEnable, GoLed, ResultValid, FalseStart and Timeout = 0; ReactionTime=0; ms counter=0; edge registers=1.
REQ-029 Reset takes priority over every input in any state, including mid-DELAY or mid-GO.
REQ-030 After reset is released, Start must fall and rise again before a new round begins.

Verification
REQ-031 Start rise; DelayDone at cycle 20; 250 MsTicks; then Press rise -> GoLed from the DelayDone edge; RESULT, ReactionTime=250, ResultValid=1, GoLed=0.
REQ-032 Press rise in DELAY before DelayDone -> FAULT, FalseStart=1, DelayEnable=0, ReactionTime=0; a following Start rise -> DELAY with FalseStart=0.
REQ-033 Press rise and DelayDone in the same cycle -> FAULT, never GO.
REQ-034 REACT_MAX=5; GO with no Press over 6 MsTicks -> Timeout=1, ReactionTime=5; repeat with Press on the 6th tick -> Timeout=0, ReactionTime=5.
REQ-035 Reset asserted in GO with counter=100 -> next edge: IDLE, all outputs 0; Start held high through reset -> no new round until Start goes 0 then 1.
REQ-036 Start pulses during DELAY/GO and Press pulses in IDLE/RESULT -> no change to State or outputs.
